// File: rtl/decoder_scan_driver_if.sv
// Control/status bundle between the scan controller and the logic that commands it.
// The slave side is the scan driver; the master side issues START/STOP/ONESHOT.
interface decoder_scan_driver_if;
  logic START;
  logic STOP;
  logic ONESHOT;
  logic S0;
  logic S1;
  logic S2;
  logic E;
  logic BUSY;
  logic WRAP;

  modport master (
    output START, STOP, ONESHOT,
    input  S0, S1, S2, E, BUSY, WRAP
  );

  modport slave (
    input  START, STOP, ONESHOT,
    output S0, S1, S2, E, BUSY, WRAP
  );
endinterface

// File: rtl/decoder_scan_driver.sv
// Scans a 3-to-8 decoder through channels 0..7 with an enable-low blanking gap
// before each enable-high dwell, so select lines only move while E is low.
module decoder_scan_driver #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1
) (
  input logic                  CLK,
  input logic                  RST_N,
  decoder_scan_driver_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  localparam logic [7:0] BLANK_LD = 8'(BLANK - 1);
  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);

  state_t     state;
  logic [2:0] ch;
  logic [7:0] cnt;
  logic       os;
  logic       e;
  logic       busy;
  logic       wrap;

  // The select outputs come straight from the channel flop, so S moves only
  // on the edges that load ch (entering BLANK, or reset).
  assign bus.S0   = ch[0];
  assign bus.S1   = ch[1];
  assign bus.S2   = ch[2];
  assign bus.E    = e;
  assign bus.BUSY = busy;
  assign bus.WRAP = wrap;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      ch    <= '0;
      cnt   <= '0;
      os    <= 1'b0;
      e     <= 1'b0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          e    <= 1'b0;
          busy <= 1'b0;
          if (bus.START && !bus.STOP) begin
            ch    <= '0;
            os    <= bus.ONESHOT;
            cnt   <= BLANK_LD;
            busy  <= 1'b1;
            state <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (bus.STOP) begin
            e     <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == 8'd0) begin
            cnt   <= DWELL_LD;
            e     <= 1'b1;
            state <= ST_DRIVE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DRIVE: begin
          if (bus.STOP) begin
            e     <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            e <= 1'b0;
            if (ch != 3'd7) begin
              ch    <= ch + 3'd1;
              cnt   <= BLANK_LD;
              state <= ST_BLANK;
            end else begin
              // End of frame: one-shot parks on channel 7, continuous restarts at 0.
              wrap <= 1'b1;
              if (os) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                ch    <= '0;
                cnt   <= BLANK_LD;
                state <= ST_BLANK;
              end
            end
          end
        end
        default: begin
          e     <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/decoder_scan_driver.md
# decoder_scan_driver

Sequential scan controller that drives the select and enable inputs of the 3-to-8 decoder stage directly downstream (S0/S1/S2/E). It steps through channels 0..7 with a programmable enable-high dwell and an enable-low blanking gap between channels, so the select lines never change while the decoder is enabled. It supports continuous and one-shot sweeps and reports busy and frame-wrap status to the controlling logic.

## Interface
- DWELL, default 4: cycles E is held high per channel; legal range 1..255.
- BLANK, default 1: cycles E is held low before each channel; legal range 1..255.
- CLK  in  1  single clock; all logic is on the rising edge.
- RST_N  in  1  reset, synchronous and active-low.
- START  in  1  level-sampled; starts a sweep when high in IDLE.
- STOP  in  1  level-sampled; aborts any sweep and returns to IDLE.
- ONESHOT  in  1  sampled together with START: 1 = single sweep, 0 = continuous.
- S0  out  1  decoder select bit 0 (LSB).
- S1  out  1  decoder select bit 1.
- S2  out  1  decoder select bit 2 (MSB).
- E  out  1  decoder enable.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- WRAP  out  1  one-cycle pulse marking the completion of channel 7's dwell.

## Operation
- All outputs are registered. Internal state: FSM, 3-bit channel register `ch`, 8-bit down-counter `cnt`, and a latched one-shot flag `os`.
- Reset (RST_N=0 at an edge) forces: state IDLE, ch=0, cnt=0, os=0, S2..S0=000, E=0, BUSY=0, WRAP=0. Reset overrides every other input, including mid-sweep.
- IDLE:
  - E=0, BUSY=0, and S2..S0 hold their last value.
  - START=1 with STOP=0: set ch=0, drive S=000, latch os=ONESHOT, load cnt=BLANK-1, go to BLANK.
- BLANK:
  - E=0. When cnt=0, load cnt=DWELL-1 and go to DRIVE. Otherwise decrement cnt.
- DRIVE:
  - E=1. When cnt>0, decrement cnt.
  - When cnt=0 and ch≠7: increment ch, update S, load cnt=BLANK-1, go to BLANK.
  - When cnt=0 and ch=7: assert WRAP for the next cycle. If os=1, go to IDLE. If os=0, set ch=0 (S=000), load BLANK-1, go to BLANK.
- STOP=1 in BLANK or DRIVE: the next state is IDLE and E=0. S holds, WRAP is not asserted, and any pending channel advance is discarded.
- Precedence: RST_N > STOP > terminal-count transitions. START+STOP in the same IDLE cycle leaves the block in IDLE. START while BUSY is ignored, and ONESHOT is not re-sampled.
- Invariant: S2..S0 change only on the edge that enters BLANK or IDLE. S never changes in a cycle where E=1, and is never changed on the same edge that raises E.
- Channel order is strictly 0,1,2,...,7 and then 0 again in continuous mode; there is no skipping.

## Timing
- Let START be sampled at edge k:
  - Cycles k+1..k+BLANK: BLANK, with E=0, S=000, BUSY=1.
  - Cycles k+BLANK+1..k+BLANK+DWELL: E=1 with S=000.
- Per-channel period = BLANK+DWELL cycles. Frame period = 8·(BLANK+DWELL); with the defaults, 40 cycles.
- WRAP is high for exactly one cycle: the cycle immediately after channel 7's last E=1 cycle. In one-shot mode this is the first IDLE cycle, which has BUSY=0.
- One-shot sweep: BUSY is high for exactly 8·(BLANK+DWELL) cycles.
- STOP sampled at edge m: E=0 and BUSY=0 from cycle m+1.
- DWELL=1 and BLANK=1 are legal: E alternates 0,1 every cycle while S advances on each rising edge that lowers E.

## Test plan
- Reset: hold RST_N=0 for 3 cycles while START=1. Required: S=000, E=0, BUSY=0, WRAP=0 throughout, and the sweep starts only after RST_N=1.
- Continuous sweep with defaults: pulse START with ONESHOT=0. Required: S steps 0→7→0 with E pattern 0,1,1,1,1 per channel, a WRAP pulse every 40 cycles, and no S change while E=1.
- One-shot: START with ONESHOT=1. Required: BUSY is high for 40 cycles, WRAP pulses in the first IDLE cycle, and afterwards E=0 with S held at 111.
- STOP mid-DRIVE on channel 3 (cycle 2 of its dwell). Required: the next cycle has E=0, BUSY=0, S=011, and no WRAP.
- Simultaneous START+STOP in IDLE: stays IDLE. Then START alone: sweep begins at channel 0. START pulses during a sweep: no effect on sequence or timing.
- DWELL=1, BLANK=1 instance in continuous mode: E toggles every cycle, frame = 16 cycles, WRAP every 16 cycles. Reset asserted mid-frame returns all outputs to reset values on the next edge.
